block_timer: RTL and testbench
==============================

# block_timer

Parametrised block timer for the ALFSR datapath. It counts enabled cycles up to a programmable terminal value and steps through a bounded set of blocks. It raises a one-cycle restart pulse after every terminal count and flags block selections outside the valid range. Sits between the top-level controller (load/enable) and the ALFSR core, which it re-seeds via `restart`.

## Interface
Parameters:
- `WIDTH`, 16, cycle-counter width in bits
- `BLK_W`, 3, block-index width in bits
- `NUM_BLKS`, 6, number of valid blocks; indices 0..NUM_BLKS-1; must be ≤ 2^BLK_W

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `en`  in  1  count enable
- `load`  in  1  latch `term` and `blk_sel`, restart counting
- `term`  in  WIDTH  terminal count, sampled on `load`
- `blk_sel`  in  BLK_W  starting block, sampled on `load`
- `q`  out  WIDTH  current cycle count
- `blk`  out  BLK_W  current block index
- `cout`  out  1  combinational: terminal reached this cycle (RUN & en & q==term_r)
- `wrap`  out  1  combinational: cout & (blk == NUM_BLKS-1)
- `restart`  out  1  registered one-cycle pulse, cycle after `cout`
- `error`  out  1  sticky invalid-block flag
- `busy`  out  1  state is RUN or FLUSH

## Operation
- States: IDLE, RUN, FLUSH, ERR.
- Priority each cycle: `reset` > `load` > `en`.
- `load` (any state): term_r←`term`, q←0.
  - If `blk_sel` < NUM_BLKS: blk←`blk_sel`, error←0, →RUN.
  - Otherwise: blk←0, error←1, →ERR.
- RUN, `en`=0: hold q.
- RUN, `en`=1, q≠term_r: q←q+1.
- RUN, `en`=1, q==term_r: `cout`=1, q←0. blk←blk+1, or 0 when blk==NUM_BLKS-1 (`wrap`=1). →FLUSH.
- FLUSH: `restart`=1 for exactly this cycle. q frozen, `en` ignored. →RUN.
- ERR: q and blk hold 0, `en` ignored, `error`=1. Leave only via `reset` or a valid `load`.
- IDLE: `en` ignored. q=0, blk=0.
- term_r=0: terminal on every enabled RUN cycle. Sequence alternates RUN/FLUSH, giving `restart` every 2nd cycle with `en` held high.
- term_r=2^WIDTH-1: full-range count; q never overflows past term_r.
- Arithmetic: q increment is modulo 2^WIDTH. Block comparison is unsigned on BLK_W bits.

## Timing
- Reset values:
  - state IDLE
  - q=0, blk=0, term_r=0
  - `restart`=0, `error`=0, `busy`=0
  - `cout`=0, `wrap`=0
- `load` in cycle N: new q/blk/state visible in cycle N+1. `cout` cannot assert in cycle N.
- Terminal count:
  - `cout`/`wrap` assert in the cycle q==term_r with `en` high.
  - `restart` asserts in the next cycle.
  - q=0 and the new blk are visible in that same `restart` cycle.
- Period with `en` held high: term_r+2 cycles per block (term_r+1 counting cycles plus one FLUSH).
- `load` during FLUSH: `load` wins, and `restart` still pulses that cycle (already registered). Next state follows the `load` rules.
- `reset` mid-RUN/FLUSH: all outputs return to reset values next cycle, with no `restart` pulse afterwards.
- `error` rises the cycle after an invalid `load` and stays high until `reset` or a valid `load`.

## Structure
- Package `block_timer_pkg`:
  - state enum (IDLE, RUN, FLUSH, ERR)
  - default `NUM_BLKS`, `BLK_W`, `WIDTH` constants
- Sub-module `tc_counter`: WIDTH-bit up-counter with sync clear, enable, terminal compare. Outputs q and `tc`.
- FSM, block index register, restart register and error flag live in `block_timer`.

## Test plan
- Reset, then `load` term=3, blk_sel=0, `en` high → q 0,1,2,3. `cout` at q=3, `restart` next cycle, blk=1, period 5 cycles.
- term=0, blk_sel=4, `en` high → `cout` every 2nd cycle. blk 4→5→0 with `wrap`=1 on the 5→0 step.
- `load` blk_sel=6 → `error`=1, state ERR, `en` ignored. Then `load` blk_sel=2 → `error`=0, blk=2, counting resumes.
- RUN with `en` toggled 1,0,1,0 at term=2 → q advances only on `en`=1 cycles. `cout` exactly once at q=2.
- `reset` asserted in FLUSH cycle → next cycle all outputs 0, no further `restart`. `load` during FLUSH → `restart` pulse still observed, q=0, new blk taken.
- term=16'hFFFF, `en` high → `cout` only at q=FFFF. q returns to 0, never exceeds term.

Source files
------------

// File: rtl/block_timer_pkg.sv
// rtl/block_timer_pkg.sv - shared types and default sizes for the block timer
// Purpose: FSM state encoding plus default WIDTH / BLK_W / NUM_BLKS values.
// Ports: none (package).
package block_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_BLK_W    = 3;
  localparam int DEF_NUM_BLKS = 6;

endpackage

// File: rtl/block_timer_if.sv
// rtl/block_timer_if.sv - controller-side bundle of the block timer
// Purpose: groups the load/enable controls and the timer status outputs.
// Ports (signals): en, load, term, blk_sel (controller -> timer);
//                  q, blk, cout, wrap, restart, error, busy (timer -> controller).
// Modports: master = controller, slave = timer.
interface block_timer_if
  import block_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLK_W = DEF_BLK_W
) ();

  logic             en;
  logic             load;
  logic [WIDTH-1:0] term;
  logic [BLK_W-1:0] blk_sel;
  logic [WIDTH-1:0] q;
  logic [BLK_W-1:0] blk;
  logic             cout;
  logic             wrap;
  logic             restart;
  logic             error;
  logic             busy;

  modport master (
    output en, load, term, blk_sel,
    input  q, blk, cout, wrap, restart, error, busy
  );

  modport slave (
    input  en, load, term, blk_sel,
    output q, blk, cout, wrap, restart, error, busy
  );

endinterface

// File: rtl/block_timer_tc_counter.sv
// rtl/block_timer_tc_counter.sv - up-counter with sync clear and terminal compare
// Purpose: WIDTH-bit cycle counter used by block_timer.
// Ports: clk, reset (sync, active-high), clr (sync clear), en (count),
//        term (terminal value), q (count), tc (q == term).
module tc_counter
  import block_timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + WIDTH'(1);
    end
  end

  assign tc = (q == term);

endmodule

// File: rtl/block_timer.sv
// rtl/block_timer.sv - programmable block timer with restart pulse and block stepping
// Purpose: counts enabled cycles to term_r, steps the block index, pulses restart
//          one cycle after each terminal count, flags invalid block selections.
// Ports: clk, reset (sync, active-high), bus (block_timer_if.slave:
//        en, load, term, blk_sel in; q, blk, cout, wrap, restart, error, busy out).
module block_timer
  import block_timer_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int BLK_W    = DEF_BLK_W,
  parameter int NUM_BLKS = DEF_NUM_BLKS
) (
  input logic         clk,
  input logic         reset,
  block_timer_if.slave bus
);

  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLKS - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] term_r;
  logic [WIDTH-1:0] q_w;
  logic [BLK_W-1:0] blk_r;
  logic             restart_r;
  logic             error_r;
  logic             tc;
  logic             sel_ok;
  logic             cout_c;
  logic             wrap_c;
  logic             busy_c;
  logic             cnt_clr;
  logic             cnt_en;

  // One extra bit so NUM_BLKS == 2**BLK_W still compares correctly.
  assign sel_ok = ({1'b0, bus.blk_sel} < (BLK_W + 1)'(NUM_BLKS));

  // Counter clears on load and on terminal; it only advances below terminal.
  assign cnt_clr = bus.load | cout_c;
  assign cnt_en  = (state == ST_RUN) & bus.en & ~tc;

  tc_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (term_r),
    .q     (q_w),
    .tc    (tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (bus.load) begin
      state_nx = sel_ok ? ST_RUN : ST_ERR;
    end else begin
      case (state)
        ST_RUN:   if (bus.en && tc) state_nx = ST_FLUSH;
        ST_FLUSH: state_nx = ST_RUN;
        ST_ERR:   state_nx = ST_ERR;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Output logic; load suppresses a terminal in its own cycle.
  always_comb begin
    cout_c = 1'b0;
    wrap_c = 1'b0;
    busy_c = 1'b0;
    if (state == ST_RUN || state == ST_FLUSH) busy_c = 1'b1;
    if (state == ST_RUN && bus.en && !bus.load && tc) cout_c = 1'b1;
    if (cout_c && blk_r == LAST_BLK) wrap_c = 1'b1;
  end

  // Terminal value, block index, restart pulse and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      term_r    <= '0;
      blk_r     <= '0;
      restart_r <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      restart_r <= cout_c;
      if (bus.load) begin
        term_r  <= bus.term;
        blk_r   <= sel_ok ? bus.blk_sel : '0;
        error_r <= ~sel_ok;
      end else if (cout_c) begin
        blk_r <= wrap_c ? '0 : blk_r + BLK_W'(1);
      end
    end
  end

  assign bus.q       = q_w;
  assign bus.blk     = blk_r;
  assign bus.cout    = cout_c;
  assign bus.wrap    = wrap_c;
  assign bus.restart = restart_r;
  assign bus.error   = error_r;
  assign bus.busy    = busy_c;

endmodule

// File: tb/tb_block_timer.sv
// tb/tb_block_timer.sv - self-checking bench for block_timer
module tb_block_timer;
  import block_timer_pkg::*;

  localparam int W  = 16;
  localparam int BW = 3;
  localparam int NB = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  block_timer_if #(.WIDTH(W), .BLK_W(BW)) bif ();

  block_timer #(.WIDTH(W), .BLK_W(BW), .NUM_BLKS(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Apply inputs just after the falling edge, then let combinational outputs settle.
  task automatic drive(input logic e, input logic l, input logic [15:0] t,
                       input logic [2:0] s, input logic r);
    @(negedge clk);
    reset       = r;
    bif.en      = e;
    bif.load    = l;
    bif.term    = t;
    bif.blk_sel = s;
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, 16'd0, 3'd0, 1);
    drive(1, 0, 16'd0, 3'd0, 1);
    checks++;
    if ({bif.q, bif.blk, bif.restart, bif.error, bif.busy, bif.cout, bif.wrap} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got q=%h blk=%0d rst=%b err=%b busy=%b cout=%b wrap=%b want all 0",
               bif.q, bif.blk, bif.restart, bif.error, bif.busy, bif.cout, bif.wrap);
    end
    drive(1, 0, 16'd0, 3'd0, 0);
    checks++;
    if (bif.busy !== 1'b0 || bif.q !== 16'd0) begin
      errors++;
      $display("FAIL idle_ignores_en got busy=%b q=%h want busy=0 q=0", bif.busy, bif.q);
    end
  endtask

  task automatic test_basic_count;
    int exp_q [12] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0, 1};
    int exp_c [12] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    int exp_r [12] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int exp_b [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2};
    drive(1, 1, 16'd3, 3'd0, 0);
    checks++;
    if (bif.cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_load_cout got %b want 0", bif.cout);
    end
    for (int k = 0; k < 12; k++) begin
      drive(1, 0, 16'd0, 3'd0, 0);
      checks++;
      if (bif.q !== 16'(exp_q[k]) || bif.cout !== 1'(exp_c[k]) ||
          bif.restart !== 1'(exp_r[k]) || bif.blk !== 3'(exp_b[k]) || bif.busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_k%0d got q=%0d cout=%b rst=%b blk=%0d busy=%b want q=%0d cout=%0d rst=%0d blk=%0d busy=1",
                 k, bif.q, bif.cout, bif.restart, bif.blk, bif.busy, exp_q[k], exp_c[k], exp_r[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_wrap;
    int exp_c [5] = '{1, 0, 1, 0, 1};
    int exp_w [5] = '{0, 0, 1, 0, 0};
    int exp_b [5] = '{4, 5, 5, 0, 0};
    int exp_r [5] = '{0, 1, 0, 1, 0};
    drive(1, 1, 16'd0, 3'd4, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 16'd0, 3'd0, 0);
      checks++;
      if (bif.cout !== 1'(exp_c[k]) || bif.wrap !== 1'(exp_w[k]) ||
          bif.blk !== 3'(exp_b[k]) || bif.restart !== 1'(exp_r[k]) || bif.q !== 16'd0) begin
        errors++;
        $display("FAIL wrap_k%0d got cout=%b wrap=%b blk=%0d rst=%b q=%0d want cout=%0d wrap=%0d blk=%0d rst=%0d q=0",
                 k, bif.cout, bif.wrap, bif.blk, bif.restart, bif.q, exp_c[k], exp_w[k], exp_b[k], exp_r[k]);
      end
    end
  endtask

  task automatic test_error;
    int exp_q [3] = '{0, 1, 0};
    int exp_c [3] = '{0, 1, 0};
    int exp_b [3] = '{2, 2, 3};
    drive(1, 1, 16'd2, 3'd6, 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 16'd0, 3'd0, 0);
      checks++;
      if (bif.error !== 1'b1 || bif.busy !== 1'b0 || bif.q !== 16'd0 ||
          bif.blk !== 3'd0 || bif.cout !== 1'b0 || bif.restart !== 1'b0) begin
        errors++;
        $display("FAIL err_hold_k%0d got err=%b busy=%b q=%0d blk=%0d cout=%b rst=%b want err=1 busy=0 q=0 blk=0 cout=0 rst=0",
                 k, bif.error, bif.busy, bif.q, bif.blk, bif.cout, bif.restart);
      end
    end
    drive(1, 1, 16'd1, 3'd2, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 16'd0, 3'd0, 0);
      checks++;
      if (bif.error !== 1'b0 || bif.q !== 16'(exp_q[k]) ||
          bif.cout !== 1'(exp_c[k]) || bif.blk !== 3'(exp_b[k])) begin
        errors++;
        $display("FAIL err_recover_k%0d got err=%b q=%0d cout=%b blk=%0d want err=0 q=%0d cout=%0d blk=%0d",
                 k, bif.error, bif.q, bif.cout, bif.blk, exp_q[k], exp_c[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_en_toggle;
    int exp_q [6] = '{0, 1, 1, 2, 2, 0};
    int ncout = 0;
    drive(0, 1, 16'd2, 3'd0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(((k % 2) == 0), 0, 16'd0, 3'd0, 0);
      if (bif.cout === 1'b1) ncout++;
      checks++;
      if (bif.q !== 16'(exp_q[k]) || bif.cout !== (k == 4)) begin
        errors++;
        $display("FAIL en_toggle_k%0d got q=%0d cout=%b want q=%0d cout=%0d",
                 k, bif.q, bif.cout, exp_q[k], (k == 4));
      end
    end
    checks++;
    if (ncout != 1) begin
      errors++;
      $display("FAIL en_toggle_cout_count got %0d want 1", ncout);
    end
  endtask

  task automatic test_flush;
    drive(1, 1, 16'd0, 3'd1, 0);
    drive(1, 0, 16'd0, 3'd0, 0);
    checks++;
    if (bif.cout !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre_cout got %b want 1", bif.cout);
    end
    drive(1, 0, 16'd0, 3'd0, 1);
    checks++;
    if (bif.restart !== 1'b1) begin
      errors++;
      $display("FAIL flush_reset_restart got %b want 1", bif.restart);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 16'd0, 3'd0, 0);
      checks++;
      if ({bif.q, bif.blk, bif.restart, bif.error, bif.busy, bif.cout, bif.wrap} !== '0) begin
        errors++;
        $display("FAIL flush_reset_k%0d got q=%h blk=%0d rst=%b err=%b busy=%b cout=%b wrap=%b want all 0",
                 k, bif.q, bif.blk, bif.restart, bif.error, bif.busy, bif.cout, bif.wrap);
      end
    end
    drive(1, 1, 16'd1, 3'd0, 0);
    drive(1, 0, 16'd0, 3'd0, 0);
    drive(1, 0, 16'd0, 3'd0, 0);
    checks++;
    if (bif.cout !== 1'b1 || bif.q !== 16'd1) begin
      errors++;
      $display("FAIL flush_load_pre got cout=%b q=%0d want cout=1 q=1", bif.cout, bif.q);
    end
    drive(1, 1, 16'd5, 3'd3, 0);
    checks++;
    if (bif.restart !== 1'b1 || bif.cout !== 1'b0) begin
      errors++;
      $display("FAIL flush_load_restart got rst=%b cout=%b want rst=1 cout=0", bif.restart, bif.cout);
    end
    drive(1, 0, 16'd0, 3'd0, 0);
    checks++;
    if (bif.q !== 16'd0 || bif.blk !== 3'd3 || bif.restart !== 1'b0 || bif.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_load_after got q=%0d blk=%0d rst=%b busy=%b want q=0 blk=3 rst=0 busy=1",
               bif.q, bif.blk, bif.restart, bif.busy);
    end
    drive(1, 0, 16'd0, 3'd0, 0);
    checks++;
    if (bif.q !== 16'd1) begin
      errors++;
      $display("FAIL flush_load_count got q=%0d want 1", bif.q);
    end
  endtask

  task automatic test_full_range;
    int ncout = 0;
    int pos = -1;
    int qbad = 0;
    drive(1, 1, 16'hFFFF, 3'd0, 0);
    for (int k = 0; k <= 65536; k++) begin
      drive(1, 0, 16'd0, 3'd0, 0);
      if (k <= 65535 && bif.q !== 16'(k)) qbad++;
      if (bif.cout === 1'b1) begin
        ncout++;
        pos = k;
      end
    end
    checks++;
    if (ncout != 1 || pos != 65535) begin
      errors++;
      $display("FAIL full_cout got count=%0d pos=%0d want count=1 pos=65535", ncout, pos);
    end
    checks++;
    if (qbad != 0) begin
      errors++;
      $display("FAIL full_q_seq got %0d bad cycles want 0", qbad);
    end
    checks++;
    if (bif.q !== 16'd0 || bif.restart !== 1'b1 || bif.blk !== 3'd1) begin
      errors++;
      $display("FAIL full_after got q=%h rst=%b blk=%0d want q=0 rst=1 blk=1", bif.q, bif.restart, bif.blk);
    end
  endtask

  // Behavioural model: counting/flushing phases tracked as plain flags.
  task automatic test_random;
    int  mq = 0, mb = 0, mt = 0;
    bit  merr = 0, mcnt = 0, mfl = 0, mrst = 0, mcout, mwrap;
    bit  r, l, e;
    int  t, s;
    logic [25:0] got, want;
    drive(0, 0, 16'd0, 3'd0, 1);
    for (int k = 0; k < 2000; k++) begin
      r = ($urandom_range(0, 49) == 0);
      l = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 3) != 0);
      t = $urandom_range(0, 4);
      s = $urandom_range(0, 7);
      drive(e, l, 16'(t), 3'(s), r);
      mcout = mcnt && e && !l && (mq == mt);
      mwrap = mcout && (mb == NB - 1);
      got  = {bif.q, bif.blk, bif.restart, bif.error, bif.busy, bif.cout, bif.wrap, 2'b00};
      want = {16'(mq), 3'(mb), mrst, merr, (mcnt || mfl), mcout, mwrap, 2'b00};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_k%0d got q=%h blk=%0d rst=%b err=%b busy=%b cout=%b wrap=%b want q=%h blk=%0d rst=%b err=%b busy=%b cout=%b wrap=%b",
                 k, bif.q, bif.blk, bif.restart, bif.error, bif.busy, bif.cout, bif.wrap,
                 mq, mb, mrst, merr, (mcnt || mfl), mcout, mwrap);
      end
      if (r) begin
        mq = 0; mb = 0; mt = 0; merr = 0; mcnt = 0; mfl = 0; mrst = 0;
      end else begin
        mrst = mcout;
        if (l) begin
          mt = t; mq = 0; mfl = 0;
          if (s < NB) begin mb = s; merr = 0; mcnt = 1; end
          else        begin mb = 0; merr = 1; mcnt = 0; end
        end else if (mfl) begin
          mfl = 0; mcnt = 1;
        end else if (mcout) begin
          mq = 0; mb = (mb + 1) % NB; mcnt = 0; mfl = 1;
        end else if (mcnt && e) begin
          mq = (mq + 1) % 65536;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_wrap();
    test_error();
    test_en_toggle();
    test_flush();
    test_full_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
